// File: rtl/booth2_pp_resolver.sv
// booth2_pp_resolver: consumer end of the Booth2 compressor. Captures the two
// compressed partial products and aligns PPout2 to weight 2^2. A slice-serial
// carry-propagate adder then resolves them into the 16-bit product, which is
// returned through a valid/ready handshake.
module booth2_pp_resolver #(
  parameter int SLICE_W = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] pp1_in,
  input  logic [13:0] pp2_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  localparam int NSLICE = 16 / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  // Only widths that tile the 16-bit word exactly are supported.
  generate
    if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 ||
          SLICE_W == 8 || SLICE_W == 16)) begin : g_bad_slice_w
      $error("booth2_pp_resolver: SLICE_W must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [15:0]       a_q;
  logic [15:0]       b_q;
  logic [15:0]       res_q;
  logic [15:0]       prod_q;
  logic [CW-1:0]     cnt_q;
  logic              cy_q;
  logic              rdy_q;
  logic              vld_q;
  logic              busy_q;

  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W:0]   sum;
  logic [15:0]        res_d;
  logic               cy_d;

  // One slice of the ripple adder: pick slice cnt_q of both operands, add with
  // the carry from the previous slice, and merge the sum into the running result.
  always_comb begin
    sa    = '0;
    sb    = '0;
    res_d = res_q;
    for (int s = 0; s < NSLICE; s++) begin
      if (cnt_q == CW'(s)) begin
        sa = a_q[s*SLICE_W +: SLICE_W];
        sb = b_q[s*SLICE_W +: SLICE_W];
      end
    end
    sum  = {1'b0, sa} + {1'b0, sb} + {{SLICE_W{1'b0}}, cy_q};
    cy_d = sum[SLICE_W];
    for (int s = 0; s < NSLICE; s++) begin
      if (cnt_q == CW'(s)) begin
        res_d[s*SLICE_W +: SLICE_W] = sum[SLICE_W-1:0];
      end
    end
  end

  // Control FSM with registered handshake outputs. The product register loads
  // only on entry to DONE, so it never shows a partially resolved sum. The
  // carry out of the top slice is dropped: the sign encoding produces it legally.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (in_valid && rdy_q) begin
            a_q     <= pp1_in;
            b_q     <= {pp2_in, 2'b00};
            res_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          res_q <= res_d;
          cy_q  <= cy_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            prod_q  <= res_d;
            vld_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign product   = prod_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth2_pp_resolver.sv
// Bench for booth2_pp_resolver: a default-width instance exercised scenario by
// scenario, plus instances at SLICE_W = 1, 2, 8 and 16 driven with random pairs.
module tb_booth2_pp_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pp1_in;
  logic [13:0] pp2_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  logic [3:0]  sv_valid;
  logic [3:0]  sv_ready;
  logic [3:0]  sv_ovalid;
  logic [3:0]  sv_busy;
  logic [15:0] sv_prod [4];
  logic [15:0] sw_pp1;
  logic [13:0] sw_pp2;
  logic        sw_oready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth2_pp_resolver #(.SLICE_W(4)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp1_in    (pp1_in),
    .pp2_in    (pp2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    booth2_pp_resolver #(.SLICE_W(gi == 0 ? 1 : gi == 1 ? 2 : gi == 2 ? 8 : 16)) u_dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .in_valid  (sv_valid[gi]),
      .in_ready  (sv_ready[gi]),
      .pp1_in    (sw_pp1),
      .pp2_in    (sw_pp2),
      .out_valid (sv_ovalid[gi]),
      .out_ready (sw_oready),
      .product   (sv_prod[gi]),
      .busy      (sv_busy[gi])
    );
  end

  // in_ready and out_valid must never be high together on the main instance.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (in_ready && out_valid) begin
        errors++;
        $display("FAIL rdy_vld_exclusive at %0t: in_ready=%b out_valid=%b required not both 1",
                 $time, in_ready, out_valid);
      end
    end
  end

  function automatic logic [15:0] model(input int unsigned a, input int unsigned b);
    int unsigned full;
    full = a + b * 4;
    return 16'(full % 65536);
  endfunction

  // Drive one operand pair into the main instance and wait for out_valid.
  task automatic run_op(input logic [15:0] a, input logic [13:0] b,
                        output int lat, output logic [15:0] p, output bit ok);
    ok  = 1'b1;
    lat = 0;
    p   = 16'h0;
    for (int i = 0; i < 32 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      ok = 1'b0;
      return;
    end
    in_valid = 1'b1;
    pp1_in   = a;
    pp2_in   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pp1_in   = 16'($urandom);
    pp2_in   = 14'($urandom);
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) ok = 1'b0;
    p = product;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pp1_in    = 16'h0;
    pp2_in    = 14'h0;
    sv_valid  = 4'b0;
    sw_pp1    = 16'h0;
    sw_pp2    = 14'h0;
    sw_oready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h want=0000", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (sv_ready !== 4'b0) begin errors++; $display("FAIL reset_sweep_ready got=%b want=0000", sv_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_basic();
    int lat; logic [15:0] p; bit ok;
    out_ready = 1'b1;
    run_op(16'h0012, 14'h0003, lat, p, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no out_valid want=out_valid"); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d want=4", lat); end
    checks++; if (p !== 16'h001E) begin errors++; $display("FAIL basic_product got=%h want=001e", p); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got=%b want=1", busy); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    checks++; if (product !== 16'h001E) begin errors++; $display("FAIL basic_product_hold got=%h want=001e", product); end
  endtask

  task automatic test_carry_chain();
    int lat; logic [15:0] p; bit ok;
    out_ready = 1'b1;
    run_op(16'h7FFF, 14'h0001, lat, p, ok);
    checks++; if (!ok || p !== 16'h8003) begin errors++; $display("FAIL carry_chain got=%h ok=%b want=8003", p, ok); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency got=%0d want=4", lat); end
    run_op(16'hFFFF, 14'h0001, lat, p, ok);
    checks++; if (!ok || p !== 16'h0003) begin errors++; $display("FAIL wrap_product got=%h ok=%b want=0003", p, ok); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency got=%0d want=4", lat); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL wrap_ctrl got busy=%b rdy=%b want 1/0", busy, in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL wrap_after got vld=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_pressure();
    int lat; logic [15:0] p; bit ok;
    out_ready = 1'b0;
    run_op(16'h0012, 14'h0003, lat, p, ok);
    checks++; if (!ok || p !== 16'h001E) begin errors++; $display("FAIL bp_first got=%h ok=%b want=001e", p, ok); end
    in_valid = 1'b1;
    pp1_in   = 16'h7FFF;
    pp2_in   = 14'h0001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || product !== 16'h001E) begin
        errors++;
        $display("FAIL bp_stall cycle %0d got rdy=%b vld=%b prod=%h want 0/1/001e", i, in_ready, out_valid, product);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || product !== 16'h001E) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b busy=%b prod=%h want 0/1/0/001e", out_valid, in_ready, busy, product);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_second_accept got busy=%b rdy=%b want 1/0", busy, in_ready);
    end
    in_valid = 1'b0;
    pp1_in   = 16'($urandom);
    pp2_in   = 14'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_second_latency got=%0d want=4", lat); end
    checks++; if (product !== 16'h8003) begin errors++; $display("FAIL bp_second_product got=%h want=8003", product); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit seen;
    out_ready = 1'b1;
    for (int i = 0; i < 32 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    pp1_in   = 16'h1234;
    pp2_in   = 14'h0101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL midrst_product got=%h want=0000", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready got=%b want=1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid || product !== 16'h0000 || busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_stale got=activity after reset want=none"); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] p; bit ok;
    int unsigned a, b;
    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = $urandom_range(0, 65535);
      b = $urandom_range(0, 16383);
      run_op(16'(a), 14'(b), lat, p, ok);
      checks++;
      if (!ok || p !== model(a, b) || lat !== 4) begin
        errors++;
        $display("FAIL random_w4 pair %0d a=%h b=%h got=%h lat=%0d want=%h lat=4", n, a, b, p, lat, model(a, b));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_param_sweep();
    int widths [4] = '{1, 2, 8, 16};
    int unsigned a, b;
    int lat;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 1000; n++) begin
        a = $urandom_range(0, 65535);
        b = $urandom_range(0, 16383);
        for (int i = 0; i < 32 && !sv_ready[k]; i++) begin
          @(posedge clk); #1;
        end
        checks++;
        if (!sv_ready[k]) begin
          errors++;
          $display("FAIL sweep_w%0d_ready_timeout got=0 want=1", widths[k]);
          continue;
        end
        sv_valid[k] = 1'b1;
        sw_pp1      = 16'(a);
        sw_pp2      = 14'(b);
        @(posedge clk); #1;
        sv_valid[k] = 1'b0;
        sw_pp1      = 16'($urandom);
        sw_pp2      = 14'($urandom);
        lat = 0;
        while (!sv_ovalid[k] && lat < 64) begin
          @(posedge clk); #1;
          lat++;
        end
        checks++;
        if (lat !== 16 / widths[k]) begin
          errors++;
          $display("FAIL sweep_w%0d_latency pair %0d got=%0d want=%0d", widths[k], n, lat, 16 / widths[k]);
        end
        checks++;
        if (sv_prod[k] !== model(a, b)) begin
          errors++;
          $display("FAIL sweep_w%0d_product pair %0d a=%h b=%h got=%h want=%h", widths[k], n, a, b, sv_prod[k], model(a, b));
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_pressure();
    test_mid_reset();
    test_random();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
